// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// With SERIAL_SUB_ADD_MODE_EN defined the bundle also carries Mode
// (1 = add, 0 = subtract), captured together with A/B.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             Mode;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    // Requester side: drives the operands and start, observes the result.
    modport master (
        output start,
        output A,
        output B,
`ifdef SERIAL_SUB_ADD_MODE_EN
        output Mode,
`endif
        input  busy,
        input  done,
        input  Diff,
        input  Bout,
        input  Ovf
    );

    // Arithmetic unit side.
    modport slave (
        input  start,
        input  A,
        input  B,
`ifdef SERIAL_SUB_ADD_MODE_EN
        input  Mode,
`endif
        output busy,
        output done,
        output Diff,
        output Bout,
        output Ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor: Diff = A - B over WIDTH
// cycles using one full-subtractor cell and a borrow flop.
// Optional macro SERIAL_SUB_ADD_MODE_EN adds a captured Mode bit; Mode=1
// turns the cell into a full adder (Bout becomes carry out).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; result outputs hold the last result
// S_RUN  | one operand bit pair per cycle, WIDTH cycles, busy=1
// S_DONE | single cycle, done=1, Diff/Bout/Ovf freshly valid
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             mode_q, mode_d;
`endif

    logic             a0, b0;
    logic             bit_res;
    logic             brw_nxt;
    logic             ovf_nxt;

    // One-bit arithmetic cell plus the overflow rule applied to the final bit.
    always_comb begin
        a0      = a_sh_q[0];
        b0      = b_sh_q[0];
        bit_res = a0 ^ b0 ^ brw_q;
        brw_nxt = (~a0 & b0) | (~(a0 ^ b0) & brw_q);
        ovf_nxt = (a_msb_q != b_msb_q) && (bit_res != a_msb_q);
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (mode_q) begin
            brw_nxt = (a0 & b0) | (brw_q & (a0 ^ b0));
            ovf_nxt = (a_msb_q == b_msb_q) && (bit_res != a_msb_q);
        end
`endif
    end

    // Next-state and datapath update; result registers load only on DONE entry.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        mode_d   = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.A;
                    b_sh_d   = bus.B;
                    a_msb_d  = bus.A[WIDTH-1];
                    b_msb_d  = bus.B[WIDTH-1];
                    res_sh_d = '0;
                    brw_d    = 1'b0;
                    cnt_d    = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    mode_d   = bus.Mode;
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                res_sh_d = {bit_res, res_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                brw_d    = brw_nxt;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    diff_d  = {bit_res, res_sh_q[WIDTH-1:1]};
                    bout_d  = brw_nxt;
                    ovf_d   = ovf_nxt;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q   <= mode_d;
`endif
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): table of operand/result
// vectors plus hand-written sequences for ignored start and mid-run reset.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         mode;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full operation: start pulse, count busy cycles, bounded wait for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                          input logic [W-1:0] ediff, input logic ebout, input logic eovf);
        int busy_cnt;
        int done_cyc;
        busy_cnt = 0;
        done_cyc = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.Mode  = mode;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.Mode  = ~mode;
`endif
        for (int cyc = 1; cyc <= 3 * W; cyc++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
        end
        chk($sformatf("done_cycle %h-%h", a, b), done_cyc, W + 1);
        chk($sformatf("busy_cycles %h-%h", a, b), busy_cnt, W);
        chk($sformatf("diff %h-%h", a, b), bus.Diff, ediff);
        chk($sformatf("bout %h-%h", a, b), bus.Bout, ebout);
        chk($sformatf("ovf %h-%h", a, b), bus.Ovf, eovf);
        @(negedge clk);
        chk($sformatf("done_drop %h-%h", a, b), bus.done, 1'b0);
        chk($sformatf("diff_hold %h-%h", a, b), bus.Diff, ediff);
    endtask

    initial begin
        int done_cnt;
        logic [W-1:0] seen_diff;

        vecs.push_back('{8'h0A, 8'h03, 1'b0, 8'h07, 1'b0, 1'b0});
        vecs.push_back('{8'h03, 8'h0A, 1'b0, 8'hF9, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1});
        vecs.push_back('{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'hFF, 1'b0, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1});
        vecs.push_back('{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1});
        vecs.push_back('{8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0});
`ifdef SERIAL_SUB_ADD_MODE_EN
        vecs.push_back('{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b0});
`endif

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.Mode  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset diff", bus.Diff, 8'h00);
        chk("reset bout", bus.Bout, 1'b0);
        chk("reset ovf",  bus.Ovf,  1'b0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].diff, vecs[i].bout, vecs[i].ovf);

        // start pulsed during RUN must be ignored
        done_cnt  = 0;
        seen_diff = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h0A;
        bus.B     = 8'h03;
`ifdef SERIAL_SUB_ADD_MODE_EN
        bus.Mode  = 1'b0;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 3 * W; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                bus.start = 1'b1;
                bus.A     = 8'hFF;
                bus.B     = 8'h00;
            end
            if (cyc == 4) bus.start = 1'b0;
            if (bus.done) begin
                done_cnt++;
                seen_diff = bus.Diff;
            end
        end
        chk("ignored_start done_count", done_cnt, 1);
        chk("ignored_start diff", seen_diff, 8'h07);
        chk("ignored_start busy_idle", bus.busy, 1'b0);

        // reset in the middle of RUN aborts the operation
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h55;
        bus.B     = 8'h11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", bus.busy, 1'b0);
        chk("abort done", bus.done, 1'b0);
        chk("abort diff", bus.Diff, 8'h00);
        chk("abort bout", bus.Bout, 1'b0);
        chk("abort ovf",  bus.Ovf,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 2 * W; cyc++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        chk("abort no_activity", done_cnt, 0);
        run_op(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first two's-complement subtractor: Diff = A - B over WIDTH cycles, using one full-subtractor cell and a borrow flip-flop.
- Inverse companion to the combinational full-adder cell; trades area for latency in the datapath library.
- Start/busy/done handshake; results held until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend, captured on accepted start.
- B  input  WIDTH  subtrahend, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result valid.
- Diff  output  WIDTH  result register.
- Bout  output  1  final borrow out (unsigned A < B).
- Ovf  output  1  signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, Diff=0, Bout=0, Ovf=0; shift registers, borrow FF and bit counter cleared.
- States:
  - IDLE: start=1 at an edge captures A and B into shift registers, saves A[WIDTH-1] and B[WIDTH-1], sets borrow=0 and count=0, then goes to RUN.
  - RUN: each edge processes bit a0/b0.
    - d = a0 ^ b0 ^ brw.
    - brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw).
    - d shifts into the result MSB; operands shift right; count increments.
    - At count == WIDTH-1 the edge goes to DONE.
  - DONE: one cycle. done=1; Diff holds the full result; Bout = final borrow; Ovf = (A_msb != B_msb) && (Diff[WIDTH-1] != A_msb). Next edge goes to IDLE.
- Latency: start accepted at edge 0, done high during the cycle after edge WIDTH. Throughput is one operation per WIDTH+2 cycles.
- busy=1 exactly while in RUN (WIDTH cycles).
- start while RUN or DONE is ignored: no restart, no queuing. start held high in IDLE begins a new operation immediately.
- A and B may change freely after capture; the result is unaffected.
- Diff, Bout and Ovf update only on entry to DONE and hold through IDLE until the next DONE. Intermediate shift contents are not visible on Diff.
- rst_n asserted mid-RUN: the operation is aborted, all outputs return to reset values, and no done pulse follows.
- Arithmetic is modulo 2^WIDTH, with no saturation.

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN.
- Defined:
  - Adds input port Mode (1 bit), captured with A/B on accepted start.
  - Mode=1 computes A + B: sum = a0 ^ b0 ^ c, c_next = (a0 & b0) | (c & (a0 ^ b0)).
  - Bout reports carry out.
  - Ovf = (A_msb == B_msb) && (Diff[WIDTH-1] != A_msb).
  - Mode=0 behaves exactly as subtract.
- Undefined: no Mode port; subtract only; behaviour as above.

Test Plan (WIDTH=8):
- A=0x0A, B=0x03, start pulse -> busy high 8 cycles, done pulse at cycle 9; Diff=0x07, Bout=0, Ovf=0.
- A=0x03, B=0x0A -> Diff=0xF9, Bout=1, Ovf=0. A=0x00, B=0x00 -> Diff=0x00, Bout=0.
- A=0x80, B=0x01 -> Diff=0x7F, Bout=0, Ovf=1. A=0x7F, B=0xFF -> Diff=0x80, Bout=1, Ovf=1.
- Start 0x0A-0x03, then pulse start with A=0xFF, B=0x00 at RUN cycle 3 -> ignored; Diff=0x07 at done; exactly one done pulse.
- Start 0x55-0x11, drop rst_n at RUN cycle 4 for 1 cycle -> all outputs 0 immediately, no done; a following start 0x20-0x10 -> Diff=0x10.
- With SERIAL_SUB_ADD_MODE_EN:
  - Mode=1, A=0xFF, B=0x01 -> Diff=0x00, Bout=1, Ovf=0.
  - Mode=1, A=0x7F, B=0x01 -> Diff=0x80, Ovf=1.
